// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues word-aligned reads on the native memory
// handshake and buffers returned words with their PCs for the decode stage.
module if_prefetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t        state, state_next;
    logic [31:0]   fetch_pc, fetch_pc_next;
    logic [31:0]   mem_addr_next;
    logic          mem_valid_next;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic          push, pop, issue_ok;
    logic [31:0]   redirect_target;

    assign redirect_target = redirect_pc & ~32'h3;
    assign out_valid       = (count != '0) && !redirect_valid;
    assign out_instr       = fifo_instr[rd_ptr];
    assign out_pc          = fifo_pc[rd_ptr];
    assign mem_instr       = mem_valid;
    assign pop             = out_valid && out_ready;
    assign push            = (state == REQ) && mem_ready && !redirect_valid;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (redirect_valid)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
    end

    // A new request is only launched once the previous one has completed, so
    // room for one more word after this cycle's push/pop is enough.
    assign issue_ok = count_next < DEPTH_C;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        mem_addr_next = mem_addr;

        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_target;
                    state_next    = REQ;
                end else if (issue_ok) begin
                    state_next = REQ;
                end
            end
            REQ, DRAIN: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_target;
                    state_next    = mem_ready ? REQ : DRAIN;
                end else if (mem_ready) begin
                    if (state == REQ)
                        fetch_pc_next = fetch_pc + 32'd4;
                    state_next = issue_ok ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // The bus address only moves when a fresh request starts; a pending
        // request keeps its address even across a redirect.
        if ((state_next == REQ) && ((state == IDLE) || mem_ready))
            mem_addr_next = fetch_pc_next;

        mem_valid_next = (state_next != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= RESET_PC;
            fetch_pc  <= RESET_PC;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_next;
            mem_valid <= mem_valid_next;
            mem_addr  <= mem_addr_next;
            fetch_pc  <= fetch_pc_next;
            count     <= count_next;
            if (redirect_valid) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: queue storage has no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= fetch_pc;
            fifo_instr[wr_ptr] <= mem_rdata;
        end
    end

    a_bus_hold: assert property (@(posedge clk) disable iff (rst)
        (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_addr)));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count <= DEPTH_C);

    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        mem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: a scoreboard of expected PCs is
// filled on memory handshakes and drained on decode handshakes.
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;

    // Second instance: wrap-around reset PC, memory and decode always ready.
    logic        w_mem_valid, w_mem_instr;
    logic [31:0] w_mem_addr, w_mem_rdata;
    logic        w_out_valid;
    logic [31:0] w_out_instr, w_out_pc;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_pc[$];
    logic [31:0] m_pc;
    logic        m_drain;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_rdata   = instr_of(mem_addr);
    assign w_mem_rdata = instr_of(w_mem_addr);

    if_prefetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_instr      (mem_instr),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    if_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (w_mem_valid),
        .mem_instr      (w_mem_instr),
        .mem_ready      (1'b1),
        .mem_addr       (w_mem_addr),
        .mem_rdata      (w_mem_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (w_out_valid),
        .out_ready      (1'b1),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc)
    );

    task automatic do_reset();
        rst            = 1'b1;
        mem_ready      = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        sb_pc.delete();
        m_pc    = 32'h0;
        m_drain = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: drive inputs after the edge, then score outputs on the falling edge.
    task automatic run_cycle(input logic rdy, input logic ordy, input logic redir,
                             input logic [31:0] tgt);
        logic [31:0] exp_pc;
        @(posedge clk);
        #1;
        mem_ready      = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        @(negedge clk);
        if (redirect_valid) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL redirect_mask: out_valid=%b, expected 0", out_valid);
            end
        end else if (out_valid && out_ready) begin
            checks++;
            if (sb_pc.size() == 0) begin
                errors++;
                $display("FAIL sb_order: delivered pc %h, expected no delivery", out_pc);
            end else begin
                exp_pc = sb_pc.pop_front();
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                    errors++;
                    $display("FAIL sb_data: got pc %h instr %h, expected pc %h instr %h",
                             out_pc, out_instr, exp_pc, instr_of(exp_pc));
                end
            end
        end
        if (redirect_valid) begin
            sb_pc.delete();
            m_drain = mem_valid && !mem_ready;
            m_pc    = redirect_pc & ~32'h3;
        end else if (mem_valid && mem_ready) begin
            if (m_drain) begin
                m_drain = 1'b0;
            end else begin
                checks++;
                if (mem_addr !== m_pc) begin
                    errors++;
                    $display("FAIL bus_addr: got %h, expected %h", mem_addr, m_pc);
                end
                sb_pc.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        mem_ready      = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || mem_instr !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: mem_valid=%b mem_instr=%b out_valid=%b, expected 0 0 0",
                     mem_valid, mem_instr, out_valid);
        end
        checks++;
        if (mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h, expected 00000000", mem_addr);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_idle: mem_valid=%b, expected 0", mem_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b1 || mem_instr !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: valid=%b instr=%b addr=%h, expected 1 1 00000000",
                     mem_valid, mem_instr, mem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] prev_pc;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (mem_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_valid: cycle %0d mem_valid=%b, expected 1", i, mem_valid);
            end
            if (i > 0) begin
                prev_pc = 32'(4 * (i - 1));
                checks++;
                if (out_valid !== 1'b1 || out_pc !== prev_pc) begin
                    errors++;
                    $display("FAIL stream_latency: cycle %0d out_valid=%b out_pc=%h, expected 1 %h",
                             i, out_valid, out_pc, prev_pc);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (mem_valid && mem_ready) nreq++;
        end
        checks++;
        if (nreq != 4 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_stop: requests=%0d mem_valid=%b, expected 4 0", nreq, mem_valid);
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_head: out_valid=%b out_pc=%h, expected 1 00000000",
                     out_valid, out_pc);
        end
        nreq = 0;
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        if (mem_valid && mem_ready) nreq++;
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
            if (mem_valid && mem_ready) nreq++;
        end
        checks++;
        if (nreq != 1 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL one_slot: requests=%0d mem_valid=%b, expected 1 0", nreq, mem_valid);
        end
        for (int i = 0; i < 6; i++)
            run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (sb_pc.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_all: left=%0d out_valid=%b, expected 0 0",
                     sb_pc.size(), out_valid);
        end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 2; k <= 5; k++) begin
            run_cycle(k == 5, k >= 3, k == 2, 32'h0000_0103);
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h8) begin
                errors++;
                $display("FAIL drain_hold: cycle %0d valid=%b addr=%h, expected 1 00000008",
                         k, mem_valid, mem_addr);
            end
        end
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL drain_target: valid=%b addr=%h, expected 1 00000100",
                     mem_valid, mem_addr);
        end
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            errors++;
            $display("FAIL drain_first_pc: out_valid=%b out_pc=%h, expected 1 00000100",
                     out_valid, out_pc);
        end
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_redirect_ready();
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0300);
        checks++;
        if (mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL redir_bus: addr=%h, expected 00000004", mem_addr);
        end
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h300 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_next: valid=%b addr=%h out_valid=%b, expected 1 00000300 0",
                     mem_valid, mem_addr, out_valid);
        end
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h300) begin
            errors++;
            $display("FAIL redir_first_pc: out_valid=%b out_pc=%h, expected 1 00000300",
                     out_valid, out_pc);
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_q[$];
        int          got = 0;
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset();
        for (int i = 0; i < 12 && got < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                checks++;
                if (w_mem_valid !== 1'b1 || w_mem_instr !== 1'b1 || w_mem_addr !== 32'hFFFF_FFF8) begin
                    errors++;
                    $display("FAIL wrap_first_req: valid=%b instr=%b addr=%h, expected 1 1 fffffff8",
                             w_mem_valid, w_mem_instr, w_mem_addr);
                end
            end
            if (w_out_valid) begin
                checks++;
                if (w_out_pc !== exp_q[0] || w_out_instr !== instr_of(exp_q[0])) begin
                    errors++;
                    $display("FAIL wrap_pc: got pc %h instr %h, expected pc %h instr %h",
                             w_out_pc, w_out_instr, exp_q[0], instr_of(exp_q[0]));
                end
                void'(exp_q.pop_front());
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d deliveries, expected 4", got);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        run_cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h4 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: valid=%b addr=%h out_valid=%b, expected 1 00000004 1",
                     mem_valid, mem_addr, out_valid);
        end
        #2 rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || out_valid !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_async: valid=%b out_valid=%b addr=%h, expected 0 0 00000000",
                     mem_valid, out_valid, mem_addr);
        end
        sb_pc.delete();
        m_pc    = 32'h0;
        m_drain = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_restart: valid=%b addr=%h, expected 1 00000000",
                     mem_valid, mem_addr);
        end
        run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL mid_first_pc: out_valid=%b out_pc=%h, expected 1 00000000",
                     out_valid, out_pc);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_ready();
        test_pc_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Instruction-fetch front end of the cpu core.
- Issues word-aligned instruction reads on the core's native memory handshake (mem_valid/mem_ready, mem_instr=1) and buffers returned words with their PCs in a small FIFO.
- Presents the buffered instructions to the decode stage over a valid/ready interface.
- Handles PC redirects (branch, jump, trap) from downstream: flushes the queue and discards any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries (power of two, 2..16).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_valid  output  1  fetch request valid.
- mem_instr  output  1  high whenever mem_valid is high.
- mem_ready  input  1  memory accepts request and returns mem_rdata this cycle.
- mem_addr  output  32  fetch address, bits[1:0] always 0.
- mem_rdata  input  32  instruction word, valid when mem_valid&&mem_ready.
- redirect_valid  input  1  one-cycle PC redirect request.
- redirect_pc  input  32  new PC; bits[1:0] ignored (forced 0).
- out_valid  output  1  instruction available to decode.
- out_ready  input  1  decode accepts.
- out_instr  output  32  instruction word at FIFO head.
- out_pc  output  32  PC of out_instr.

Behaviour:
- Reset (asynchronous, rst=1):
  - mem_valid=0, mem_instr=0, mem_addr=RESET_PC, out_valid=0.
  - FIFO empty, fetch_pc=RESET_PC, state IDLE.
- All outputs are registered except out_valid, out_instr and out_pc.
  - out_valid = (count!=0) && !redirect_valid.
  - out_instr and out_pc are the FIFO head.
- Issue rule: a request may be raised only when count + (request outstanding ? 1 : 0) < DEPTH. At most one outstanding request.
- Bus rule: once mem_valid is high, mem_valid and mem_addr must hold until the mem_ready cycle. A redirect never drops mem_valid early.
- States:
  - IDLE: mem_valid=0. Go to REQ at the next edge when the issue rule holds; set mem_addr=fetch_pc.
  - REQ: waiting on mem_ready.
    - On mem_ready: push {fetch_pc, mem_rdata}; fetch_pc += 4.
    - If the issue rule still holds (counting the push and any same-cycle pop), stay in REQ with mem_addr=new fetch_pc (back-to-back, no bubble). Otherwise go to IDLE.
  - DRAIN: in-flight request must be discarded. mem_valid stays high, same address.
    - On mem_ready: response dropped, no push. Go to REQ (mem_addr=fetch_pc) if the issue rule holds, else IDLE.
- First request: mem_valid rises on the first rising edge after rst deasserts.
- Redirect (redirect_valid=1 at an edge):
  - FIFO flushed (count=0); any same-cycle out_ready pop is ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - From IDLE: go to REQ, mem_addr=new fetch_pc on the next cycle.
  - From REQ without mem_ready: go to DRAIN.
  - From REQ with mem_ready the same cycle: response discarded; go to REQ with mem_addr=redirect target.
  - From DRAIN: target updated (last redirect wins); stay in DRAIN, or take the mem_ready exit above.
- FIFO:
  - Push and pop in the same cycle are allowed at any occupancy; the issue rule guarantees no overflow.
  - Pop when out_valid&&out_ready.
  - Pointers wrap modulo DEPTH.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset mid-transaction: all state is cleared immediately; mem_valid drops asynchronously. The memory side must also be reset.
- Formal assertions:
  - mem_valid && !mem_ready at an edge implies mem_valid and mem_addr are stable in the next cycle.
  - count <= DEPTH.
  - mem_addr[1:0] == 0.

Test Plan:
- Reset release, mem_ready tied high, out_ready high: mem_addr sequence 0x0,0x4,0x8,…, one per cycle. out_pc/out_instr follow with 1-cycle latency; mem_valid never drops.
- out_ready=0, mem_ready=1, DEPTH=4: exactly 4 requests (0x0..0xC), then mem_valid=0. Raise out_ready for one cycle: exactly one new request to 0x10.
- mem_ready delayed 3 cycles on the request to 0x8; pulse redirect_pc=0x103 in cycle 1 of the wait: mem_valid/mem_addr=0x8 held until ready, word dropped. The next request is 0x100 and the first out_pc is 0x100.
- Redirect in the same cycle as mem_ready on 0x4 with out_ready=1 and 2 entries queued: out_valid low that cycle, no entries delivered. The next mem_addr is the redirect target.
- RESET_PC=32'hFFFF_FFF8, memory always ready: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert rst while in REQ with mem_ready=0: mem_valid=0 and out_valid=0 immediately. After release, the first request is at RESET_PC.
